// File: rtl/cpu_perf_monitor_if.sv
// rtl/cpu_perf_monitor_if.sv - core-side and readout signals of the performance/halt monitor
interface cpu_perf_monitor_if #(
    parameter int CNT_W = 32,
    parameter int N_EVT = 4,
    parameter int SEL_W = $clog2(N_EVT + 1)
);
    logic [1:0]       pc_inc;
    logic [N_EVT-1:0] evt;
    logic             snap;
    logic [SEL_W-1:0] rd_sel;
    logic [CNT_W-1:0] rd_data;
    logic [CNT_W-1:0] cycle_count;
    logic [N_EVT:0]   ovf;
    logic             halt;
    logic             draining;

    modport master (
        output pc_inc, evt, snap, rd_sel,
        input  rd_data, cycle_count, ovf, halt, draining
    );

    modport slave (
        input  pc_inc, evt, snap, rd_sel,
        output rd_data, cycle_count, ovf, halt, draining
    );
endinterface

// File: rtl/cpu_perf_monitor.sv
// rtl/cpu_perf_monitor.sv - cycle/event counters, drained halt detection and snapshot bank
module cpu_perf_monitor #(
    parameter int CNT_W      = 32,
    parameter int N_EVT      = 4,
    parameter int HALT_DELAY = 3,
    parameter int SATURATE   = 0
) (
    input  logic               clk,
    input  logic               clr,
    cpu_perf_monitor_if.slave  bus
);
    localparam int              SEL_W      = $clog2(N_EVT + 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [3:0]      HALT_LIMIT = 4'(HALT_DELAY);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       stop_cnt_q, stop_cnt_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] snap_cyc_q, snap_cyc_d;
    logic [CNT_W-1:0] evt_cnt_q [N_EVT];
    logic [CNT_W-1:0] evt_cnt_d [N_EVT];
    logic [CNT_W-1:0] snap_evt_q [N_EVT];
    logic [CNT_W-1:0] snap_evt_d [N_EVT];
    logic [N_EVT:0]   ovf_q, ovf_d;
    logic             stop;
    logic             count_en;

    assign stop     = (bus.pc_inc == 2'b11);
    // The edge that enters HALTED still counts, so qualify on the pre-edge state.
    assign count_en = (state_q != S_HALTED);

    always_comb begin
        state_d    = state_q;
        stop_cnt_d = stop_cnt_q;
        case (state_q)
            S_RUN: begin
                if (stop) begin
                    stop_cnt_d = 4'd1;
                    state_d    = (HALT_LIMIT == 4'd1) ? S_HALTED : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (stop) begin
                    stop_cnt_d = stop_cnt_q + 4'd1;
                    if (stop_cnt_d == HALT_LIMIT) begin
                        state_d = S_HALTED;
                    end
                end else begin
                    // A pipeline flush squashed the stop; resume normal running.
                    stop_cnt_d = 4'd0;
                    state_d    = S_RUN;
                end
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d    = S_RUN;
                stop_cnt_d = 4'd0;
            end
        endcase
    end

    always_comb begin
        cyc_d = cyc_q;
        ovf_d = ovf_q;
        if (count_en) begin
            if (&cyc_q) begin
                ovf_d[0] = 1'b1;
                cyc_d    = (SATURATE != 0) ? cyc_q : '0;
            end else begin
                cyc_d = cyc_q + ONE;
            end
        end
        for (int i = 0; i < N_EVT; i++) begin
            evt_cnt_d[i] = evt_cnt_q[i];
            if (count_en && bus.evt[i]) begin
                if (&evt_cnt_q[i]) begin
                    ovf_d[i+1]   = 1'b1;
                    evt_cnt_d[i] = (SATURATE != 0) ? evt_cnt_q[i] : '0;
                end else begin
                    evt_cnt_d[i] = evt_cnt_q[i] + ONE;
                end
            end
        end
    end

    // Snapshot captures post-update values so a snap on the halting edge holds final counts.
    always_comb begin
        snap_cyc_d = bus.snap ? cyc_d : snap_cyc_q;
        for (int i = 0; i < N_EVT; i++) begin
            snap_evt_d[i] = bus.snap ? evt_cnt_d[i] : snap_evt_q[i];
        end
    end

    always_ff @(negedge clk) begin
        if (clr) begin
            state_q    <= S_RUN;
            stop_cnt_q <= 4'd0;
            cyc_q      <= ONE;
            snap_cyc_q <= ONE;
            ovf_q      <= '0;
            for (int i = 0; i < N_EVT; i++) begin
                evt_cnt_q[i]  <= '0;
                snap_evt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            stop_cnt_q <= stop_cnt_d;
            cyc_q      <= cyc_d;
            snap_cyc_q <= snap_cyc_d;
            ovf_q      <= ovf_d;
            for (int i = 0; i < N_EVT; i++) begin
                evt_cnt_q[i]  <= evt_cnt_d[i];
                snap_evt_q[i] <= snap_evt_d[i];
            end
        end
    end

    always_comb begin
        bus.rd_data = '0;
        if (bus.rd_sel == '0) begin
            bus.rd_data = snap_cyc_q;
        end
        for (int k = 0; k < N_EVT; k++) begin
            if (bus.rd_sel == SEL_W'(k + 1)) begin
                bus.rd_data = snap_evt_q[k];
            end
        end
    end

    assign bus.cycle_count = cyc_q;
    assign bus.ovf         = ovf_q;
    assign bus.halt        = (state_q == S_HALTED);
    assign bus.draining    = (state_q == S_DRAIN);
endmodule

// File: tb/tb_cpu_perf_monitor.sv
// tb/tb_cpu_perf_monitor.sv - three monitor configurations on shared stimulus against a counting model
module tb_cpu_perf_monitor;
    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [1:0] pc_inc = 2'b00;
    logic [3:0] evt = 4'b0000;
    logic       snap = 1'b0;
    logic [2:0] rd_sel = 3'd0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_perf_monitor_if #(.CNT_W(8),  .N_EVT(4)) if0 ();
    cpu_perf_monitor_if #(.CNT_W(8),  .N_EVT(4)) if1 ();
    cpu_perf_monitor_if #(.CNT_W(32), .N_EVT(4)) if2 ();

    assign if0.pc_inc = pc_inc; assign if0.evt = evt; assign if0.snap = snap; assign if0.rd_sel = rd_sel;
    assign if1.pc_inc = pc_inc; assign if1.evt = evt; assign if1.snap = snap; assign if1.rd_sel = rd_sel;
    assign if2.pc_inc = pc_inc; assign if2.evt = evt; assign if2.snap = snap; assign if2.rd_sel = rd_sel;

    cpu_perf_monitor #(.CNT_W(8), .N_EVT(4), .HALT_DELAY(3), .SATURATE(1))
        u0 (.clk(clk), .clr(clr), .bus(if0.slave));
    cpu_perf_monitor #(.CNT_W(8), .N_EVT(4), .HALT_DELAY(3), .SATURATE(0))
        u1 (.clk(clk), .clr(clr), .bus(if1.slave));
    cpu_perf_monitor #(.CNT_W(32), .N_EVT(4), .HALT_DELAY(1), .SATURATE(0))
        u2 (.clk(clk), .clr(clr), .bus(if2.slave));

    // Model keeps true (unbounded) counts; width, saturation and overflow are applied on readout.
    longint m_cyc [3];
    longint m_evt [3][4];
    longint m_scyc [3];
    longint m_sevt [3][4];
    int     m_run [3];
    bit     m_halt [3];
    bit     m_valid = 1'b0;

    function automatic int w_of(input int i);
        return (i == 2) ? 32 : 8;
    endfunction
    function automatic int hd_of(input int i);
        return (i == 2) ? 1 : 3;
    endfunction
    function automatic longint mx(input int i);
        return (longint'(1) << w_of(i)) - 1;
    endfunction
    function automatic longint disp(input int i, input longint v);
        if (i == 0) return (v > mx(i)) ? mx(i) : v;
        return v & mx(i);
    endfunction
    function automatic longint exp_ovf(input int i);
        longint r = 0;
        if (m_cyc[i] > mx(i)) r = r | 1;
        for (int k = 0; k < 4; k++) if (m_evt[i][k] > mx(i)) r = r | (longint'(1) << (k + 1));
        return r;
    endfunction
    function automatic longint exp_rd(input int i);
        if (rd_sel == 3'd0) return disp(i, m_scyc[i]);
        if (rd_sel <= 3'd4) return disp(i, m_sevt[i][rd_sel - 3'd1]);
        return 0;
    endfunction
    function automatic longint exp_drain(input int i);
        return (!m_halt[i] && m_run[i] > 0) ? 1 : 0;
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (clr) begin
                m_cyc[i] = 1; m_scyc[i] = 1; m_run[i] = 0; m_halt[i] = 1'b0;
                for (int k = 0; k < 4; k++) begin m_evt[i][k] = 0; m_sevt[i][k] = 0; end
            end else begin
                if (!m_halt[i]) begin
                    m_cyc[i]++;
                    for (int k = 0; k < 4; k++) if (evt[k]) m_evt[i][k]++;
                    if (pc_inc == 2'b11) begin
                        m_run[i]++;
                        if (m_run[i] >= hd_of(i)) m_halt[i] = 1'b1;
                    end else begin
                        m_run[i] = 0;
                    end
                end
                if (snap) begin
                    m_scyc[i] = m_cyc[i];
                    for (int k = 0; k < 4; k++) m_sevt[i][k] = m_evt[i][k];
                end
            end
        end
        if (clr) m_valid = 1'b1;
    end

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (m_valid) begin
            cmp("u0.cycle_count", 64'(if0.cycle_count), exp_cyc(0));
            cmp("u0.ovf",         64'(if0.ovf),         exp_ovf(0));
            cmp("u0.halt",        64'(if0.halt),        64'(m_halt[0]));
            cmp("u0.draining",    64'(if0.draining),    exp_drain(0));
            cmp("u0.rd_data",     64'(if0.rd_data),     exp_rd(0));
            cmp("u1.cycle_count", 64'(if1.cycle_count), exp_cyc(1));
            cmp("u1.ovf",         64'(if1.ovf),         exp_ovf(1));
            cmp("u1.halt",        64'(if1.halt),        64'(m_halt[1]));
            cmp("u1.draining",    64'(if1.draining),    exp_drain(1));
            cmp("u1.rd_data",     64'(if1.rd_data),     exp_rd(1));
            cmp("u2.cycle_count", 64'(if2.cycle_count), exp_cyc(2));
            cmp("u2.ovf",         64'(if2.ovf),         exp_ovf(2));
            cmp("u2.halt",        64'(if2.halt),        64'(m_halt[2]));
            cmp("u2.draining",    64'(if2.draining),    exp_drain(2));
            cmp("u2.rd_data",     64'(if2.rd_data),     exp_rd(2));
        end
    end

    function automatic longint exp_cyc(input int i);
        return disp(i, m_cyc[i]);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        tick(2);
        clr = 1'b0;
        tick(10);
        cmp("lit.count_after_10", 64'(if0.cycle_count), 64'd11);
        cmp("lit.halt_after_10",  64'(if0.halt),        64'd0);
        cmp("lit.ovf_after_10",   64'(if0.ovf),         64'd0);

        clr = 1'b1; tick(1); clr = 1'b0;
        tick(4);
        pc_inc = 2'b11;
        tick(1);
        cmp("lit.drain_edge5",  64'(if0.draining),    64'd1);
        cmp("lit.hd1_halt",     64'(if2.halt),        64'd1);
        cmp("lit.hd1_count",    64'(if2.cycle_count), 64'd6);
        tick(1);
        cmp("lit.drain_edge6",  64'(if0.draining),    64'd1);
        tick(1);
        cmp("lit.halt_edge7",   64'(if0.halt),        64'd1);
        cmp("lit.count_edge7",  64'(if0.cycle_count), 64'd8);
        tick(20);
        cmp("lit.count_frozen", 64'(if0.cycle_count), 64'd8);

        snap = 1'b1; tick(1); snap = 1'b0;
        rd_sel = 3'd0; #1;
        cmp("lit.snap_halted",  64'(if0.rd_data),     64'd8);

        clr = 1'b1; snap = 1'b1; tick(1);
        clr = 1'b0; snap = 1'b0; pc_inc = 2'b00; #1;
        cmp("lit.clr_halt",     64'(if0.halt),        64'd0);
        cmp("lit.clr_drain",    64'(if0.draining),    64'd0);
        cmp("lit.clr_count",    64'(if0.cycle_count), 64'd1);
        cmp("lit.clr_snap",     64'(if0.rd_data),     64'd1);

        pc_inc = 2'b11; tick(2);
        cmp("lit.squash_drain", 64'(if0.draining),    64'd1);
        pc_inc = 2'b00; tick(1);
        cmp("lit.squash_run",   64'(if0.draining),    64'd0);
        cmp("lit.squash_nohalt",64'(if0.halt),        64'd0);
        pc_inc = 2'b11; tick(2);
        cmp("lit.stop2_nohalt", 64'(if0.halt),        64'd0);
        tick(1);
        cmp("lit.stop3_halt",   64'(if0.halt),        64'd1);
        cmp("lit.stop3_count",  64'(if0.cycle_count), 64'd7);

        clr = 1'b1; pc_inc = 2'b00; tick(1); clr = 1'b0;
        evt = 4'b0101; tick(5);
        snap = 1'b1; tick(1); snap = 1'b0; evt = 4'b0000;
        rd_sel = 3'd1; #1; cmp("lit.evt0_snap", 64'(if0.rd_data), 64'd6);
        rd_sel = 3'd2; #1; cmp("lit.evt1_snap", 64'(if0.rd_data), 64'd0);
        rd_sel = 3'd3; #1; cmp("lit.evt2_snap", 64'(if0.rd_data), 64'd6);
        rd_sel = 3'd0; #1; cmp("lit.cyc_snap",  64'(if0.rd_data), 64'd7);
        rd_sel = 3'd7; #1; cmp("lit.sel_oor",   64'(if0.rd_data), 64'd0);

        clr = 1'b1; tick(1); clr = 1'b0;
        evt = 4'b0001; tick(299);
        snap = 1'b1; tick(1); snap = 1'b0; evt = 4'b0000;
        rd_sel = 3'd1; #1;
        cmp("lit.sat_evt",      64'(if0.rd_data),     64'd255);
        cmp("lit.sat_ovf1",     64'(if0.ovf[1]),      64'd1);
        cmp("lit.sat_ovf0",     64'(if0.ovf[0]),      64'd1);
        cmp("lit.sat_cycle",    64'(if0.cycle_count), 64'd255);
        cmp("lit.wrap_evt",     64'(if1.rd_data),     64'd44);
        cmp("lit.wrap_ovf1",    64'(if1.ovf[1]),      64'd1);
        cmp("lit.wrap_ovf0",    64'(if1.ovf[0]),      64'd1);
        cmp("lit.wrap_cycle",   64'(if1.cycle_count), 64'd45);
        cmp("lit.wide_evt",     64'(if2.rd_data),     64'd300);
        cmp("lit.wide_ovf",     64'(if2.ovf),         64'd0);
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
